execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the pipelined RISC-V core. It consumes the ID/EX pipeline register outputs and computes the ALU result, the branch decision and target, and an optional iterative 32-bit multiply. It drives the EX/MEM pipeline register internally and raises `stall_E` to the hazard logic while a multiply is in flight.

## Interface
Parameters:
- `MUL_CYCLES`, default 32: shift-add iterations per multiply; must equal operand width.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `srcA_E` in 32: operand A.
- `register_file_srcB_E` in 32: rs2 register value.
- `sign_imm_E` in 32: sign-extended immediate.
- `PC_plus4_E` in 32: PC+4 of the instruction in E.
- `rd_E` in 5: destination register.
- `ctrl_srcB_E` in 1: 1 selects `sign_imm_E` as B, 0 selects `register_file_srcB_E`.
- `ctrl_ALU_op_E` in 3: ALU operation.
- `ctrl_branch_E` in 1: instruction is BEQ.
- `ctrl_mul_E` in 1: instruction is MUL.
- `ctrl_register_file_WE_E`, `ctrl_data_memory_WE_E`, `ctrl_result_E` in 1 each: passed to MEM.
- `branch_taken_E` out 1: combinational, `ctrl_branch_E & (A==B)`.
- `PC_branch_E` out 32: combinational, `PC_plus4_E + sign_imm_E - 4`, mod 2^32.
- `stall_E` out 1: hold IF/ID/ID-EX and keep E occupied.
- `ALU_out_M`, `write_data_M`, `PC_plus4_M` out 32: EX/MEM registers.
- `rd_M` out 5: EX/MEM register.
- `ctrl_register_file_WE_M`, `ctrl_data_memory_WE_M`, `ctrl_result_M` out 1 each: EX/MEM registers.

## Operation
- B = `ctrl_srcB_E ? sign_imm_E : register_file_srcB_E`.
- ALU ops on `ctrl_ALU_op_E`, all results 32 bits with carries and overflow discarded:
  - 000: A+B
  - 001: A−B
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: signed A<B, result 1/0
  - 110: A<<B[4:0]
  - 111: logical A>>B[4:0]
- Multiply FSM with states IDLE, BUSY, DONE:
  - IDLE with `ctrl_mul_E`=1: latch A into the multiplicand register and B into the multiplier register, clear the accumulator and count, and go to BUSY.
  - BUSY: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left 1 and the multiplier right 1; increment count. At count = `MUL_CYCLES`−1 go to DONE.
  - DONE: EX/MEM captures the accumulator (low 32 bits of A×B, unsigned, equal to signed low word); go to IDLE unconditionally.
- `stall_E` = (IDLE & `ctrl_mul_E`) | BUSY. It is low in DONE.
- While `stall_E`=1, EX/MEM loads a bubble: all three `ctrl_*_M` = 0, data fields don't-care but held.
- Otherwise EX/MEM loads:
  - `ALU_out_M` = ALU result, or the product in DONE.
  - `write_data_M` = `register_file_srcB_E`.
  - `rd_M`, `PC_plus4_M` and all ctrl flags pass through.
- Branch outputs are meaningful only when not stalled. The hazard logic owns flushing on `branch_taken_E`.

## Timing
- Reset (async assert, sync release): every EX/MEM output is 0, FSM in IDLE, count, accumulator and operand registers are 0, `stall_E`=0.
- Non-multiply instruction: one cycle in E; the result appears on the `_M` outputs after the next rising edge.
- Multiply: 1 IDLE cycle + `MUL_CYCLES` BUSY cycles + 1 DONE cycle. That is 34 cycles in E with `stall_E` high for 33. The product is on `ALU_out_M` after the DONE edge.
- Back-to-back MUL: the second MUL is seen in IDLE the cycle after DONE and starts normally.
- Operands are latched at start. Changes on `srcA_E`/B during BUSY are ignored.
- Reset mid-multiply aborts immediately: IDLE, `stall_E`=0, no product written.
- Count width is ⌈log2(`MUL_CYCLES`)⌉ bits with no wrap inside BUSY.

## Configuration
- `EXECUTE_MUL_EN` defined: the FSM, operand registers and accumulator are compiled in, with behaviour as above.
- Undefined:
  - No multiply hardware is built.
  - `ctrl_mul_E` is ignored, and a MUL executes as the ALU op in `ctrl_ALU_op_E` in one cycle.
  - `stall_E` is tied to 0.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → all `_M` outputs 0 and `stall_E`=0 immediately, without a clock edge.
- ALU sweep: A=0xFFFF_FFF0, B=0x10 (register):
  - op 000 → `ALU_out_M`=0x0000_0000
  - op 101 → 1
  - op 111 → 0x0000_FFFF
  - op 110 with B=0x24 → 0xFFFF_FF00 (shift by 4)
- Branch: A=B=7, `ctrl_branch_E`=1, `PC_plus4_E`=0x104, imm=0x20 → `branch_taken_E`=1, `PC_branch_E`=0x120. With A=8 → `branch_taken_E`=0.
- Multiply (`EXECUTE_MUL_EN`): A=0x0001_0003, B=0x0000_0005:
  - `stall_E` high for exactly 33 cycles.
  - `ctrl_*_M`=0 throughout.
  - `ALU_out_M`=0x0005_000F with `ctrl_register_file_WE_M`=1 after DONE.
- Signed low word: A=0xFFFF_FFFF (−1), B=3 → `ALU_out_M`=0xFFFF_FFFD. A back-to-back second MUL 2×2 → 4 follows 34 cycles later.
- Reset at BUSY count 10 → IDLE, `stall_E`=0. A following ADD 1+2 → `ALU_out_M`=3 after one cycle.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: execute stage of the pipelined RISC-V core.
// Computes the ALU result, the BEQ decision/target and drives the EX/MEM
// pipeline register. Define EXECUTE_MUL_EN to build the iterative
// shift-add multiplier (IDLE/BUSY/DONE FSM); without it ctrl_mul_E is
// ignored and stall_E is tied low.
//
// Handshake: stall_E high means "the instruction in E has not finished";
// upstream must hold its inputs stable and EX/MEM receives a bubble
// (all ctrl_*_M = 0). An instruction retires into EX/MEM on the first rising
// edge at which stall_E is low.
//
// mul_state_dbg exposes the multiply FSM state (0 IDLE, 1 BUSY, 2 DONE).
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] srcA_E,
  input  logic [31:0] register_file_srcB_E,
  input  logic [31:0] sign_imm_E,
  input  logic [31:0] PC_plus4_E,
  input  logic [4:0]  rd_E,
  input  logic        ctrl_srcB_E,
  input  logic [2:0]  ctrl_ALU_op_E,
  input  logic        ctrl_branch_E,
  input  logic        ctrl_mul_E,
  input  logic        ctrl_register_file_WE_E,
  input  logic        ctrl_data_memory_WE_E,
  input  logic        ctrl_result_E,
  output logic        branch_taken_E,
  output logic [31:0] PC_branch_E,
  output logic        stall_E,
  output logic [31:0] ALU_out_M,
  output logic [31:0] write_data_M,
  output logic [31:0] PC_plus4_M,
  output logic [4:0]  rd_M,
  output logic        ctrl_register_file_WE_M,
  output logic        ctrl_data_memory_WE_M,
  output logic        ctrl_result_M,
  output logic [1:0]  mul_state_dbg
);

  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        mul_done;
  logic [31:0] mul_product;

  assign src_b = ctrl_srcB_E ? sign_imm_E : register_file_srcB_E;

  // Single-cycle ALU; carries and overflow are dropped.
  always_comb begin
    alu_result = 32'd0;
    case (ctrl_ALU_op_E)
      3'b000:  alu_result = srcA_E + src_b;
      3'b001:  alu_result = srcA_E - src_b;
      3'b010:  alu_result = srcA_E & src_b;
      3'b011:  alu_result = srcA_E | src_b;
      3'b100:  alu_result = srcA_E ^ src_b;
      3'b101:  alu_result = {31'd0, $signed(srcA_E) < $signed(src_b)};
      3'b110:  alu_result = srcA_E << src_b[4:0];
      default: alu_result = srcA_E >> src_b[4:0];
    endcase
  end

  // BEQ compares A against the selected B; the target is relative to PC.
  assign branch_taken_E = ctrl_branch_E & (srcA_E == src_b);
  assign PC_branch_E    = PC_plus4_E + sign_imm_E - 32'd4;

`ifdef EXECUTE_MUL_EN

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  mul_state_t      state, state_next;
  logic            mul_start;
  logic            mul_step;
  logic [31:0]     mcand;
  logic [31:0]     mplier;
  logic [31:0]     acc;
  logic [CW-1:0]   count;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: one start cycle, MUL_CYCLES iterations, one write-back cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (ctrl_mul_E) state_next = ST_BUSY;
      ST_BUSY: if (count == LAST_COUNT) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: stall covers the start cycle and every iteration.
  always_comb begin
    mul_start = 1'b0;
    mul_step  = 1'b0;
    mul_done  = 1'b0;
    case (state)
      ST_IDLE: mul_start = ctrl_mul_E;
      ST_BUSY: mul_step  = 1'b1;
      ST_DONE: mul_done  = 1'b1;
      default: ;
    endcase
    stall_E = mul_start | mul_step;
  end

  // Shift-add datapath; operands are captured once so E inputs may change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
      count  <= '0;
    end else if (mul_start) begin
      mcand  <= srcA_E;
      mplier <= src_b;
      acc    <= 32'd0;
      count  <= '0;
    end else if (mul_step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (count != LAST_COUNT) count <= count + CW'(1);
    end
  end

  assign mul_product   = acc;
  assign mul_state_dbg = state;

`else

  logic unused_mul;

  assign unused_mul    = ctrl_mul_E;
  assign stall_E       = 1'b0;
  assign mul_done      = 1'b0;
  assign mul_product   = 32'd0;
  assign mul_state_dbg = 2'd0;

`endif

  // EX/MEM register: bubble while stalled, product on the multiply's last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_out_M               <= 32'd0;
      write_data_M            <= 32'd0;
      PC_plus4_M              <= 32'd0;
      rd_M                    <= 5'd0;
      ctrl_register_file_WE_M <= 1'b0;
      ctrl_data_memory_WE_M   <= 1'b0;
      ctrl_result_M           <= 1'b0;
    end else if (stall_E) begin
      ctrl_register_file_WE_M <= 1'b0;
      ctrl_data_memory_WE_M   <= 1'b0;
      ctrl_result_M           <= 1'b0;
    end else begin
      ALU_out_M               <= mul_done ? mul_product : alu_result;
      write_data_M            <= register_file_srcB_E;
      PC_plus4_M              <= PC_plus4_E;
      rd_M                    <= rd_E;
      ctrl_register_file_WE_M <= ctrl_register_file_WE_E;
      ctrl_data_memory_WE_M   <= ctrl_data_memory_WE_E;
      ctrl_result_M           <= ctrl_result_E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized and directed bench for execute_stage with a
// reference model, an expected queue and a decoupled EX/MEM monitor.
module tb_execute_stage;

  localparam int MUL_CYCLES = 32;
  localparam int W = 104;
`ifdef EXECUTE_MUL_EN
  localparam bit MUL_BUILD = 1'b1;
`else
  localparam bit MUL_BUILD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] srcA_E, register_file_srcB_E, sign_imm_E, PC_plus4_E;
  logic [4:0]  rd_E;
  logic        ctrl_srcB_E;
  logic [2:0]  ctrl_ALU_op_E;
  logic        ctrl_branch_E, ctrl_mul_E;
  logic        ctrl_register_file_WE_E, ctrl_data_memory_WE_E, ctrl_result_E;
  logic        branch_taken_E;
  logic [31:0] PC_branch_E;
  logic        stall_E;
  logic [31:0] ALU_out_M, write_data_M, PC_plus4_M;
  logic [4:0]  rd_M;
  logic        ctrl_register_file_WE_M, ctrl_data_memory_WE_M, ctrl_result_M;
  logic [1:0]  mul_state_dbg;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_fail;

  execute_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .srcA_E(srcA_E),
    .register_file_srcB_E(register_file_srcB_E),
    .sign_imm_E(sign_imm_E),
    .PC_plus4_E(PC_plus4_E),
    .rd_E(rd_E),
    .ctrl_srcB_E(ctrl_srcB_E),
    .ctrl_ALU_op_E(ctrl_ALU_op_E),
    .ctrl_branch_E(ctrl_branch_E),
    .ctrl_mul_E(ctrl_mul_E),
    .ctrl_register_file_WE_E(ctrl_register_file_WE_E),
    .ctrl_data_memory_WE_E(ctrl_data_memory_WE_E),
    .ctrl_result_E(ctrl_result_E),
    .branch_taken_E(branch_taken_E),
    .PC_branch_E(PC_branch_E),
    .stall_E(stall_E),
    .ALU_out_M(ALU_out_M),
    .write_data_M(write_data_M),
    .PC_plus4_M(PC_plus4_M),
    .rd_M(rd_M),
    .ctrl_register_file_WE_M(ctrl_register_file_WE_M),
    .ctrl_data_memory_WE_M(ctrl_data_memory_WE_M),
    .ctrl_result_M(ctrl_result_M),
    .mul_state_dbg(mul_state_dbg)
  );

  // Clock: 10-unit period, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU from the operation table.
  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  // Zero-time check of every EX/MEM output and stall against the reset values.
  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (ALU_out_M !== 32'd0 || write_data_M !== 32'd0 || PC_plus4_M !== 32'd0 || rd_M !== 5'd0 ||
        ctrl_register_file_WE_M !== 1'b0 || ctrl_data_memory_WE_M !== 1'b0 || ctrl_result_M !== 1'b0 ||
        stall_E !== 1'b0 || mul_state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: got alu=%h wd=%h pc4=%h rd=%0d ctrl=%b%b%b stall=%b st=%0d, required all zero",
               name, ALU_out_M, write_data_M, PC_plus4_M, rd_M, ctrl_register_file_WE_M,
               ctrl_data_memory_WE_M, ctrl_result_M, stall_E, mul_state_dbg);
    end
  endtask

  // Driver: present one instruction at a falling edge, hold it while stalled.
  task automatic issue(input logic [31:0] a, input logic [31:0] rb, input logic [31:0] imm,
                       input logic [31:0] pc4, input logic [4:0] rd, input logic srcb,
                       input logic [2:0] op, input logic br, input logic mul,
                       input logic we, input logic dwe, input logic res,
                       input logic use_exp, input logic [31:0] exp_alu);
    logic [31:0] b, e, tgt;
    int stalls, exp_stalls;
    srcA_E = a; register_file_srcB_E = rb; sign_imm_E = imm; PC_plus4_E = pc4; rd_E = rd;
    ctrl_srcB_E = srcb; ctrl_ALU_op_E = op; ctrl_branch_E = br; ctrl_mul_E = mul;
    ctrl_register_file_WE_E = we; ctrl_data_memory_WE_E = dwe; ctrl_result_E = res;
    b = srcb ? imm : rb;
    if (use_exp) e = exp_alu;
    else if (MUL_BUILD && mul) e = a * b;
    else e = alu_model(op, a, b);
    tgt = pc4 + imm - 32'd4;
    exp_q.push_back({e, rb, pc4, rd, we, dwe, res});
    exp_stalls = (MUL_BUILD && mul) ? MUL_CYCLES + 1 : 0;
    #1;
    if (stall_E !== 1'b1) begin
      n_cmp++;
      if (branch_taken_E !== (br && (a == b)) || PC_branch_E !== tgt) begin
        n_fail++;
        $display("FAIL branch: got taken=%b target=%h, required taken=%b target=%h",
                 branch_taken_E, PC_branch_E, (br && (a == b)), tgt);
      end
    end
    stalls = 0;
    while (stall_E === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
      srcA_E = $urandom;
      #1;
    end
    n_cmp++;
    if (stalls != exp_stalls) begin
      n_fail++;
      $display("FAIL stall_len: got %0d stalled cycles, required %0d (op=%0d mul=%b)", stalls, exp_stalls, op, mul);
    end
    @(negedge clk);
  endtask

  task automatic issue_random();
    logic mul;
    mul = ($urandom_range(7) == 0);
    issue($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(31)), 1'($urandom_range(1)),
          3'($urandom_range(7)), 1'($urandom_range(1)), mul, 1'($urandom_range(1)),
          1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 32'd0);
  endtask

  // Monitor: every edge after a non-stalled cycle retires one instruction;
  // after a stalled cycle EX/MEM must hold a bubble.
  initial begin : monitor
    logic pre_stall, pre_rst;
    logic [W-1:0] got, exp;
    forever begin
      @(negedge clk);
      #3;
      pre_stall = stall_E;
      pre_rst   = rst_n;
      @(posedge clk);
      #1;
      if (rst_n && pre_rst) begin
        got = {ALU_out_M, write_data_M, PC_plus4_M, rd_M,
               ctrl_register_file_WE_M, ctrl_data_memory_WE_M, ctrl_result_M};
        n_cmp++;
        if (pre_stall) begin
          if (got[2:0] !== 3'b000) begin
            n_fail++;
            $display("FAIL bubble: got ctrl_M=%b, required 000", got[2:0]);
          end
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL retire: got unexpected retirement alu=%h, required none pending", ALU_out_M);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL exmem: got alu=%h wd=%h pc4=%h rd=%0d ctrl=%b, required alu=%h wd=%h pc4=%h rd=%0d ctrl=%b",
                     got[103:72], got[71:40], got[39:8], got[7:3], got[2:0],
                     exp[103:72], exp[71:40], exp[39:8], exp[7:3], exp[2:0]);
          end
        end
      end
    end
  end

  // Main sequence: reset, directed cases, random traffic, summary.
  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    srcA_E = '0; register_file_srcB_E = '0; sign_imm_E = '0; PC_plus4_E = '0; rd_E = '0;
    ctrl_srcB_E = 1'b0; ctrl_ALU_op_E = 3'd0; ctrl_branch_E = 1'b0; ctrl_mul_E = 1'b0;
    ctrl_register_file_WE_E = 1'b0; ctrl_data_memory_WE_E = 1'b0; ctrl_result_E = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    // ALU sweep on A=0xFFFF_FFF0, B=0x10 from the register file.
    issue(32'hFFFF_FFF0, 32'h10, 32'h0, 32'h1000, 5'd1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    issue(32'hFFFF_FFF0, 32'h10, 32'h0, 32'h1004, 5'd2, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
    issue(32'hFFFF_FFF0, 32'h10, 32'h0, 32'h1008, 5'd3, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_FFFF);
    issue(32'hFFFF_FFF0, 32'h24, 32'h0, 32'h100C, 5'd4, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF00);
    // Immediate-B path: 5 - 7 wraps.
    issue(32'd5, 32'h1234, 32'd7, 32'h1010, 5'd5, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);

    // BEQ taken and not taken.
    issue(32'd7, 32'd7, 32'h20, 32'h104, 5'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    issue(32'd8, 32'd7, 32'h20, 32'h104, 5'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Multiply, then signed low word, then a back-to-back 2x2.
    issue(32'h0001_0003, 32'd5, 32'h0, 32'h200, 5'd6, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, MUL_BUILD, 32'h0005_000F);
    issue(32'hFFFF_FFFF, 32'd3, 32'h0, 32'h204, 5'd7, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, MUL_BUILD, 32'hFFFF_FFFD);
    issue(32'd2, 32'd2, 32'h0, 32'h208, 5'd8, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, MUL_BUILD, 32'd4);

    // Asynchronous reset in the middle of a cycle, no clock edge needed.
    issue(32'hDEAD_0000, 32'h0000_BEEF, 32'h1, 32'hCAFE_0004, 5'd31, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef EXECUTE_MUL_EN
    // Abort a multiply at BUSY count 10, then a plain ADD 1+2.
    srcA_E = 32'h1234_5678; register_file_srcB_E = 32'h9; ctrl_srcB_E = 1'b0; ctrl_mul_E = 1'b1;
    ctrl_register_file_WE_E = 1'b1; ctrl_data_memory_WE_E = 1'b0; ctrl_result_E = 1'b0; rd_E = 5'd9;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mul_abort");
    @(negedge clk);
    rst_n = 1'b1;
`endif
    issue(32'd1, 32'd2, 32'h0, 32'h300, 5'd10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd3);

    for (int i = 0; i < 150; i++) issue_random();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
